// File: rtl/ppu_dequant_unpacker_pkg.sv
// Shared constants, FSM state type and the byte dequantization rule for the
// PPU dequant unpacker (uint8 zp=128 -> signed 32-bit accumulator domain).
package ppu_dequant_unpacker_pkg;

    localparam int ZERO_POINT     = 128;
    localparam int BYTE_W         = 8;
    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    // b - 128 reduces to flipping bit 7; the shift cannot overflow for sf <= 15.
    function automatic logic signed [WORD_W-1:0] dequant_byte(input logic [BYTE_W-1:0] b,
                                                              input logic [3:0] sf);
        logic signed [WORD_W-1:0] s;
        s = $signed({{(WORD_W-BYTE_W){1'b0}}, b}) - WORD_W'(ZERO_POINT);
        return s <<< sf;
    endfunction

endpackage

// File: rtl/ppu_dequant_unpacker_if.sv
// Input word stream and output sample stream of the dequant unpacker.
interface ppu_dequant_unpacker_if;
    import ppu_dequant_unpacker_pkg::*;

    logic                     in_valid;
    logic                     in_ready;
    logic [WORD_W-1:0]        in_data;
    logic                     in_last;
    logic [2:0]               in_nbytes;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [WORD_W-1:0] out_data;
    logic                     out_last;

    modport master (
        output in_valid, in_data, in_last, in_nbytes, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last, in_nbytes, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

endinterface

// File: rtl/ppu_dequant_unpacker_byte.sv
// Combinational single-byte dequantizer: (b - 128) <<< sf, sign-extended to 32 bits.
module ppu_dequant_byte
    import ppu_dequant_unpacker_pkg::*;
(
    input  logic [BYTE_W-1:0]        b,
    input  logic [3:0]               sf,
    output logic signed [WORD_W-1:0] q
);

    assign q = dequant_byte(b, sf);

endmodule

// File: rtl/ppu_dequant_unpacker.sv
// Unpacks four uint8 activations per word, one per cycle, into signed 32-bit
// samples; byte 0 of a new word is converted straight from in_data so words stream bubble-free.
module ppu_dequant_unpacker
    import ppu_dequant_unpacker_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            scaling_factor,
    output logic                  busy,
    ppu_dequant_unpacker_if.slave bus
);

    state_t                   state;
    logic [WORD_W-1:0]        word;
    logic [3:0]               sf;
    logic                     last;
    logic [2:0]               nbytes;
    logic [1:0]               byte_idx;

    logic                     out_fire;
    logic                     accept;
    logic                     final_byte;
    logic [1:0]               next_idx;
    logic                     next_last;
    logic [2:0]               in_nb;
    logic [BYTE_W-1:0]        conv_b;
    logic [3:0]               conv_sf;
    logic signed [WORD_W-1:0] conv_q;

    assign out_fire   = bus.out_valid & bus.out_ready;
    assign final_byte = ({1'b0, byte_idx} + 3'd1) == nbytes;
    assign next_idx   = byte_idx + 2'd1;
    assign next_last  = last & (({1'b0, next_idx} + 3'd1) == nbytes);

    assign bus.in_ready = (state == IDLE) | ((state == EMIT) & out_fire & final_byte);
    assign accept       = bus.in_valid & bus.in_ready;
    assign busy         = (state == EMIT);

    // Out-of-range counts are clamped so byte_idx can never wrap inside a word.
    always_comb begin
        in_nb = bus.in_nbytes;
        if (!bus.in_last || bus.in_nbytes == 3'd0 || bus.in_nbytes > 3'(BYTES_PER_WORD))
            in_nb = 3'(BYTES_PER_WORD);
    end

    always_comb begin
        conv_b  = word[BYTE_W*next_idx +: BYTE_W];
        conv_sf = sf;
        if (accept) begin
            conv_b  = bus.in_data[BYTE_W-1:0];
            conv_sf = scaling_factor;
        end
    end

    ppu_dequant_byte u_conv (
        .b  (conv_b),
        .sf (conv_sf),
        .q  (conv_q)
    );

    // byte_idx names the byte currently held in the output register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            word          <= '0;
            sf            <= '0;
            last          <= 1'b0;
            nbytes        <= '0;
            byte_idx      <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_last  <= 1'b0;
        end else if (accept) begin
            state         <= EMIT;
            word          <= bus.in_data;
            sf            <= scaling_factor;
            last          <= bus.in_last;
            nbytes        <= in_nb;
            byte_idx      <= '0;
            bus.out_valid <= 1'b1;
            bus.out_data  <= conv_q;
            bus.out_last  <= bus.in_last & (in_nb == 3'd1);
        end else if (out_fire) begin
            if (final_byte) begin
                state         <= IDLE;
                bus.out_valid <= 1'b0;
                bus.out_last  <= 1'b0;
            end else begin
                byte_idx     <= next_idx;
                bus.out_data <= conv_q;
                bus.out_last <= next_last;
            end
        end
    end

endmodule

// File: tb/tb_ppu_dequant_unpacker.sv
// Directed + randomized bench for ppu_dequant_unpacker against a queue-based sample model.
module tb_ppu_dequant_unpacker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] scaling_factor;
    logic       busy;

    ppu_dequant_unpacker_if bus();

    ppu_dequant_unpacker dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .scaling_factor (scaling_factor),
        .busy           (busy),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [2:0]  nb;
        logic [3:0]  sf;
    } word_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } samp_t;

    word_t wq[$];
    samp_t eq[$];
    samp_t got[$];
    int    got_cyc[$];

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int rdy_mode = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_data;
    logic        prev_last;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Reference: sample = (b - 128) * 2^sf as plain integer arithmetic.
    function automatic logic [31:0] model(input logic [7:0] b, input logic [3:0] sf);
        int v;
        v = (int'(b) - 128) * (1 << sf);
        return v;
    endfunction

    function automatic int eff_nb(input logic last, input logic [2:0] nb);
        if (!last || nb == 3'd0) return 4;
        return int'(nb);
    endfunction

    task automatic push_word(input logic [31:0] d, input logic l, input logic [2:0] nb,
                             input logic [3:0] sf);
        word_t w;
        w.data = d; w.last = l; w.nb = nb; w.sf = sf;
        wq.push_back(w);
    endtask

    // One clock: drive inputs, check against model, then advance past the edge.
    task automatic tick();
        word_t w;
        samp_t s;
        int    n;
        logic  exp_rdy;
        bus.in_valid = (wq.size() > 0);
        if (wq.size() > 0) begin
            bus.in_data    = wq[0].data;
            bus.in_last    = wq[0].last;
            bus.in_nbytes  = wq[0].nb;
            scaling_factor = wq[0].sf;
        end else begin
            bus.in_data    = $urandom;
            bus.in_last    = 1'($urandom);
            bus.in_nbytes  = 3'($urandom);
            scaling_factor = 4'($urandom);
        end
        case (rdy_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = 1'($urandom_range(0, 1));
            default: bus.out_ready = (cyc % 3 == 0);
        endcase
        #1;
        check("out_valid", 32'(bus.out_valid), 32'(eq.size() != 0));
        check("busy", 32'(busy), 32'(eq.size() != 0));
        exp_rdy = (eq.size() == 0) || (eq.size() == 1 && bus.out_valid && bus.out_ready);
        check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        if (prev_stall) begin
            check("stall_data", bus.out_data, prev_data);
            check("stall_last", 32'(bus.out_last), 32'(prev_last));
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_data  = bus.out_data;
        prev_last  = bus.out_last;
        if (bus.out_valid && bus.out_ready && eq.size() > 0) begin
            s = eq.pop_front();
            check("out_data", bus.out_data, s.data);
            check("out_last", 32'(bus.out_last), 32'(s.last));
            got.push_back('{data: bus.out_data, last: bus.out_last});
            got_cyc.push_back(cyc);
        end
        if (bus.in_valid && bus.in_ready) begin
            w = wq.pop_front();
            n = eff_nb(w.last, w.nb);
            for (int k = 0; k < n; k++)
                eq.push_back('{data: model(w.data[8*k +: 8], w.sf), last: w.last && (k == n - 1)});
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((wq.size() > 0 || eq.size() > 0) && guard < 2000) begin
            tick();
            guard++;
        end
        check("drain_timeout", 32'(guard < 2000), 32'd1);
        tick();
    endtask

    initial begin
        logic signed [31:0] d;
        int rec;
        logic [7:0] b0, b1, b2, b3;
        int sfs[2] = '{6, 8};

        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.in_nbytes = '0;
        bus.out_ready = 1'b0; scaling_factor = 4'd8;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", bus.out_data, 32'd0);
        check("rst_out_last", 32'(bus.out_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        rst_n = 1'b1;

        // single word
        got.delete(); got_cyc.delete(); rdy_mode = 0;
        push_word(32'h00FF8081, 1'b0, 3'd0, 4'd8);
        drain();
        check("single_count", got.size(), 32'd4);
        if (got.size() == 4) begin
            check("single_b0", got[0].data, 32'h00000100);
            check("single_b1", got[1].data, 32'h00000000);
            check("single_b2", got[2].data, 32'h00007F00);
            check("single_b3", got[3].data, 32'hFFFF8000);
            check("single_last", 32'(got[3].last), 32'd0);
        end

        // back-to-back words, one sample per cycle
        got.delete(); got_cyc.delete(); rdy_mode = 0;
        for (int i = 0; i < 3; i++) push_word($urandom, 1'b0, 3'd0, 4'($urandom_range(1, 15)));
        drain();
        check("b2b_count", got.size(), 32'd12);
        if (got.size() == 12) check("b2b_span", got_cyc[11] - got_cyc[0], 32'd11);

        // backpressure 1,0,0 pattern
        got.delete(); got_cyc.delete(); rdy_mode = 2;
        push_word(32'hA55A0FF0, 1'b0, 3'd0, 4'd6);
        push_word(32'h13579BDF, 1'b1, 3'd3, 4'd8);
        drain();
        check("bp_count", got.size(), 32'd7);

        // partial last word
        got.delete(); got_cyc.delete(); rdy_mode = 0;
        push_word(32'h1234FF00, 1'b1, 3'd2, 4'd6);
        drain();
        check("part_count", got.size(), 32'd2);
        if (got.size() == 2) begin
            check("part_b0", got[0].data, 32'hFFFFE000);
            check("part_b1", got[1].data, 32'h00001FC0);
            check("part_last0", 32'(got[0].last), 32'd0);
            check("part_last1", 32'(got[1].last), 32'd1);
        end

        // round trip: every byte at sf=6 and sf=8, random backpressure
        rdy_mode = 1;
        foreach (sfs[j]) begin
            got.delete(); got_cyc.delete();
            for (int i = 0; i < 64; i++) begin
                b0 = 8'(4*i); b1 = 8'(4*i+1); b2 = 8'(4*i+2); b3 = 8'(4*i+3);
                push_word({b3, b2, b1, b0}, 1'b0, 3'd0, 4'(sfs[j]));
            end
            drain();
            check("rt_count", got.size(), 32'd256);
            for (int i = 0; i < got.size(); i++) begin
                d   = got[i].data;
                rec = int'(d >>> sfs[j]) + 128;
                check("roundtrip", rec, i);
            end
        end

        // random words: random last/nbytes/sf/backpressure
        for (int i = 0; i < 40; i++)
            push_word($urandom, 1'($urandom), 3'($urandom_range(0, 4)), 4'($urandom_range(1, 15)));
        drain();

        // reset mid-word after two of four bytes
        got.delete(); got_cyc.delete(); rdy_mode = 0;
        push_word(32'h44332211, 1'b0, 3'd0, 4'd8);
        tick(); tick(); tick();
        check("pre_rst_count", got.size(), 32'd2);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        eq.delete(); wq.delete(); prev_stall = 0;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        got.delete(); got_cyc.delete();
        push_word(32'h88776655, 1'b1, 3'd0, 4'd6);
        drain();
        check("post_rst_count", got.size(), 32'd4);
        if (got.size() > 0) check("post_rst_b0", got[0].data, 32'hFFFFF540);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
